// File: rtl/cnn_mul_arb_pkg.sv
// Shared constants and types for the conv1 multiplier arbiter.
// The optional per-requester accept counters are built only when
// CNN_MUL_ARB_PERF_EN is defined.
`timescale 1ns/1ps
package cnn_mul_arb_pkg;
  localparam int CNN_A_W     = 14;
  localparam int CNN_B_W     = 7;
  localparam int CNN_P_W     = 21;
  localparam int CNN_NUM_REQ = 4;
  localparam int CNN_TAG_W   = $clog2(CNN_NUM_REQ);
  localparam int PERF_CNT_W  = 16;

  typedef logic [CNN_TAG_W-1:0] tag_t;

  // Next round-robin position after index idx in a ring of n entries.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/cnn_mul_arbiter_if.sv
// Bus between the conv1 PE lanes (master) and the shared multiplier (slave).
// Operands are packed per lane; results come back on one shared data bus.
`timescale 1ns/1ps
interface cnn_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = cnn_mul_arb_pkg::CNN_A_W,
  parameter int B_W     = cnn_mul_arb_pkg::CNN_B_W,
  parameter int P_W     = cnn_mul_arb_pkg::CNN_P_W,
  parameter int TAG_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = cnn_mul_arb_pkg::PERF_CNT_W
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*A_W-1:0]   req_a;
  logic [NUM_REQ*B_W-1:0]   req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       res_valid;
  logic [P_W-1:0]           res_data;
  logic [TAG_W-1:0]         res_tag;
  logic [NUM_REQ*CNT_W-1:0] perf_cnt;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_data, res_tag, perf_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_data, res_tag, perf_cnt
  );
endinterface

// File: rtl/cnn_mul_arb_rr.sv
// Round-robin grant logic: the first requester at or after the pointer wins.
`timescale 1ns/1ps
module cnn_mul_arb_rr #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan from the pointer with wraparound; only the first hit is granted.
  always_comb begin
    int w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/cnn_mul_arbiter.sv
// Shares one pipelined signed multiplier between NUM_REQ conv1 requesters.
// Round-robin operand selection, input register, MUL_LAT-2 middle registers
// and an output register; the requester tag rides along with each product.
// Define CNN_MUL_ARB_PERF_EN to build the 16-bit per-requester accept counters.
`timescale 1ns/1ps
module cnn_mul_arbiter
  import cnn_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = CNN_A_W,
  parameter int B_W     = CNN_B_W,
  parameter int P_W     = CNN_P_W,
  parameter int MUL_LAT = 3
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  cnn_mul_arbiter_if.slave bus
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int NSTG  = MUL_LAT - 1;

  logic [NUM_REQ-1:0]    w_req;
  logic [NUM_REQ-1:0]    w_grant;
  logic [TAG_W-1:0]      w_idx;
  logic                  w_accept;
  logic [TAG_W-1:0]      r_ptr;

  logic signed [A_W-1:0] w_sel_a;
  logic signed [B_W-1:0] w_sel_b;

  logic                  r_in_v;
  logic signed [A_W-1:0] r_in_a;
  logic signed [B_W-1:0] r_in_b;
  logic [TAG_W-1:0]      r_in_tag;

  logic signed [P_W-1:0] w_ext_a;
  logic signed [P_W-1:0] w_ext_b;
  logic signed [P_W-1:0] w_prod;

  logic                  r_stg_v [NSTG];
  logic signed [P_W-1:0] r_stg_p [NSTG];
  logic [TAG_W-1:0]      r_stg_t [NSTG];

  // Nobody is granted while reset is held.
  assign w_req = bus.req_valid & {NUM_REQ{~ap_rst}};

  cnn_mul_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_accept)
  );

  assign bus.req_ready = w_grant;

  // Route the granted lane's operands to the multiplier input register.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = bus.req_a[i*A_W +: A_W];
        w_sel_b = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  // Move the pointer just past the winner; it holds when nothing is accepted.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= TAG_W'(wrapInc(int'(w_idx), NUM_REQ));
    end
  end

  // Input register: operands load only on an accept so idle cycles don't toggle it.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_in_v   <= 1'b0;
      r_in_a   <= '0;
      r_in_b   <= '0;
      r_in_tag <= '0;
    end else begin
      r_in_v <= w_accept;
      if (w_accept) begin
        r_in_a   <= w_sel_a;
        r_in_b   <= w_sel_b;
        r_in_tag <= w_idx;
      end
    end
  end

  // Sign-extend both operands to the product width so the multiply is exact.
  assign w_ext_a = {{(P_W-A_W){r_in_a[A_W-1]}}, r_in_a};
  assign w_ext_b = {{(P_W-B_W){r_in_b[B_W-1]}}, r_in_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Product/tag shift pipeline; each stage's data only loads when its input is valid.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int k = 0; k < NSTG; k++) begin
        r_stg_v[k] <= 1'b0;
        r_stg_p[k] <= '0;
        r_stg_t[k] <= '0;
      end
    end else begin
      r_stg_v[0] <= r_in_v;
      if (r_in_v) begin
        r_stg_p[0] <= w_prod;
        r_stg_t[0] <= r_in_tag;
      end
      for (int k = 1; k < NSTG; k++) begin
        r_stg_v[k] <= r_stg_v[k-1];
        if (r_stg_v[k-1]) begin
          r_stg_p[k] <= r_stg_p[k-1];
          r_stg_t[k] <= r_stg_t[k-1];
        end
      end
    end
  end

  assign bus.res_data = r_stg_p[NSTG-1];
  assign bus.res_tag  = r_stg_t[NSTG-1];

  // Decode the output tag into the one-hot result strobe.
  always_comb begin
    bus.res_valid = '0;
    bus.res_valid[r_stg_t[NSTG-1]] = r_stg_v[NSTG-1];
  end

`ifdef CNN_MUL_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] r_perf [NUM_REQ];

  // Per-requester accept counters; they wrap naturally at the counter width.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_perf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) r_perf[i] <= r_perf[i] + PERF_CNT_W'(1);
      end
    end
  end

  // Pack the counters onto the perf bus, lane i in slice i.
  always_comb begin
    bus.perf_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.perf_cnt[i*PERF_CNT_W +: PERF_CNT_W] = r_perf[i];
    end
  end
`else
  assign bus.perf_cnt = '0;
`endif

endmodule

// File: tb/tb_cnn_mul_arbiter.sv
// Self-checking bench for cnn_mul_arbiter (NUM_REQ=4, MUL_LAT=3).
// A queue-based reference model predicts grants, results and counters each cycle.
`timescale 1ns/1ps
module tb_cnn_mul_arbiter;
  import cnn_mul_arb_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 3;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] expReady;
  } arbVec_t;

  typedef struct {
    int a;
    int b;
    int expProd;
  } mulVec_t;

  typedef struct {
    int due;
    int tag;
    int prod;
  } expRes_t;

  logic clk;
  logic rst;

  cnn_mul_arbiter_if #(.NUM_REQ(NR)) bus ();

  cnn_mul_arbiter #(
    .NUM_REQ (NR),
    .A_W     (CNN_A_W),
    .B_W     (CNN_B_W),
    .P_W     (CNN_P_W),
    .MUL_LAT (LAT)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [3:0] stimValid;
  int stimA [NR];
  int stimB [NR];

  int         mPtr;
  int         mGrant;
  int         lastData;
  expRes_t    expQ [$];
  logic [15:0] mPerf [NR];

  arbVec_t arbTab [19];
  mulVec_t mulTab [4];

  task automatic cmp(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus();
    bus.req_valid = stimValid;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*CNN_A_W +: CNN_A_W] = CNN_A_W'(stimA[i]);
      bus.req_b[i*CNN_B_W +: CNN_B_W] = CNN_B_W'(stimB[i]);
    end
  endtask

  function automatic int modelGrant(input logic [3:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(mPtr + k) % NR]) return (mPtr + k) % NR;
    end
    return -1;
  endfunction

  // Compare every DUT output with what the model predicts for this cycle.
  task automatic checkOutput();
    logic [3:0]  expReady;
    logic [3:0]  expValid;
    logic [63:0] expPerf;
    expRes_t     e;
    if (rst) begin
      expQ.delete();
      mPtr     = 0;
      lastData = 0;
      for (int i = 0; i < NR; i++) mPerf[i] = '0;
      mGrant = -1;
    end else begin
      mGrant = modelGrant(stimValid);
    end
    expReady = (mGrant < 0) ? 4'b0000 : 4'(1 << mGrant);
    cmp("req_ready", bus.req_ready, expReady);

    expValid = 4'b0000;
    if (expQ.size() > 0 && expQ[0].due == cycle) begin
      e        = expQ.pop_front();
      expValid = 4'(1 << e.tag);
      lastData = e.prod;
      cmp("res_tag", bus.res_tag, e.tag);
    end
    cmp("res_valid", bus.res_valid, expValid);
    cmp("res_data", $signed(bus.res_data), lastData);

    expPerf = '0;
`ifdef CNN_MUL_ARB_PERF_EN
    for (int i = 0; i < NR; i++) expPerf[i*16 +: 16] = mPerf[i];
`endif
    cmp("perf_cnt", bus.perf_cnt, expPerf);
  endtask

  // One clock: check at the falling edge, advance the model, land 1 ns after the rising edge.
  task automatic step();
    @(negedge clk);
    checkOutput();
    if (!rst && mGrant >= 0) begin
      expQ.push_back('{due: cycle + LAT, tag: mGrant, prod: stimA[mGrant] * stimB[mGrant]});
      mPerf[mGrant] = mPerf[mGrant] + 16'd1;
      mPtr = (mGrant + 1) % NR;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic randOperands();
    for (int i = 0; i < NR; i++) begin
      stimA[i] = int'($urandom_range(0, 16383)) - 8192;
      stimB[i] = int'($urandom_range(0, 127)) - 64;
    end
  endtask

  task automatic drain(input int n);
    stimValid = 4'b0000;
    applyStimulus();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Arbitration vectors from a freshly reset pointer; each row's expectation
    // follows from the previous winner.
    arbTab[0]  = '{4'b1111, 4'b0001};
    arbTab[1]  = '{4'b1111, 4'b0010};
    arbTab[2]  = '{4'b1111, 4'b0100};
    arbTab[3]  = '{4'b1111, 4'b1000};
    arbTab[4]  = '{4'b1111, 4'b0001};
    arbTab[5]  = '{4'b1111, 4'b0010};
    arbTab[6]  = '{4'b1111, 4'b0100};
    arbTab[7]  = '{4'b1111, 4'b1000};
    arbTab[8]  = '{4'b0100, 4'b0100};
    arbTab[9]  = '{4'b1001, 4'b1000};
    arbTab[10] = '{4'b1001, 4'b0001};
    arbTab[11] = '{4'b1001, 4'b1000};
    arbTab[12] = '{4'b1001, 4'b0001};
    arbTab[13] = '{4'b0110, 4'b0010};
    arbTab[14] = '{4'b0000, 4'b0000};
    arbTab[15] = '{4'b0011, 4'b0001};
    arbTab[16] = '{4'b0011, 4'b0010};
    arbTab[17] = '{4'b0000, 4'b0000};
    arbTab[18] = '{4'b1000, 4'b1000};

    mulTab[0] = '{8191, -64, -524224};
    mulTab[1] = '{-8192, 63, -516096};
    mulTab[2] = '{0, -1, 0};
    mulTab[3] = '{-8192, -64, 524288};

    rst       = 1'b1;
    stimValid = 4'b0000;
    for (int i = 0; i < NR; i++) begin
      stimA[i] = 0;
      stimB[i] = 0;
    end
    applyStimulus();
    mPtr = 0;
    lastData = 0;
    for (int i = 0; i < NR; i++) mPerf[i] = '0;

    // Reset state.
    step();
    step();
    rst = 1'b0;
    step();

    // Table-driven arbitration: rotation, fairness, withdrawn requests.
    for (int t = 0; t < 19; t++) begin
      randOperands();
      stimValid = arbTab[t].valid;
      applyStimulus();
      #1;
      cmp($sformatf("arbTab%0d", t), bus.req_ready, arbTab[t].expReady);
      step();
    end
    drain(LAT + 1);

    // Lone requester 2 at the most negative corner, granted every cycle.
    stimValid = 4'b0100;
    stimA[2]  = -8192;
    stimB[2]  = -64;
    applyStimulus();
    step();
    step();
    step();
    cmp("req2_data", $signed(bus.res_data), 524288);
    cmp("req2_tag", bus.res_tag, 2);
    cmp("req2_valid", bus.res_valid, 4'b0100);
    step();
    step();
    drain(LAT + 1);

    // Signed extremes, one at a time through requester 1.
    for (int t = 0; t < 4; t++) begin
      stimValid = 4'b0010;
      stimA[1]  = mulTab[t].a;
      stimB[1]  = mulTab[t].b;
      applyStimulus();
      step();
      drain(2);
      cmp($sformatf("mulTab%0d_data", t), $signed(bus.res_data), mulTab[t].expProd);
      cmp($sformatf("mulTab%0d_valid", t), bus.res_valid, 4'b0010);
      step();
    end

    // Reset with two products in flight: nothing may emerge, pointer back to 0.
    randOperands();
    stimValid = 4'b0001;
    applyStimulus();
    step();
    stimValid = 4'b0010;
    applyStimulus();
    step();
    rst       = 1'b1;
    stimValid = 4'b1111;
    applyStimulus();
    step();
    step();
    rst       = 1'b0;
    stimValid = 4'b0000;
    applyStimulus();
    for (int i = 0; i < LAT + 1; i++) step();
    stimValid = 4'b1111;
    applyStimulus();
    #1;
    cmp("ptrAfterReset", bus.req_ready, 4'b0001);
    step();
    drain(LAT + 1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      randOperands();
      stimValid = 4'($urandom_range(0, 15));
      applyStimulus();
      step();
    end
    drain(LAT + 1);

`ifdef CNN_MUL_ARB_PERF_EN
    // Counter wrap: 65537 accepts by requester 1 leave lane 1 at 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    stimValid = 4'b0010;
    randOperands();
    applyStimulus();
    for (int n = 0; n < 65537; n++) step();
    drain(LAT + 1);
    cmp("perfWrap", bus.perf_cnt, 64'h0000_0000_0001_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
